// File: rtl/sevenseg_mux_n.sv
// sevenseg_mux_n
// Time-multiplexed driver for DIGITS common-select seven-segment digits.
// Each digit owns a slot of CLK_DIV clocks: a dead-time window of
// BLANK_CYCLES (select released to stop ghosting), then a lit window whose
// length follows the 4-bit brightness, then dark for the rest of the slot.
// Display data is latched once per frame so a digit never changes mid-scan.
//
// Optional build macro: SEVENSEG_LZ_BLANK_EN
//   defined   -> leading zeros (nibble 0 with no dp, from the top digit
//                down) are kept dark; digit 0 always shows.
//   undefined -> every digit shows its nibble, zeros included.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   value        4*DIGITS hex nibbles, nibble i drives digit i
//   dp_in        decimal point request per digit
//   blank_mask   1 keeps that digit dark for its slot
//   bright       brightness 0 (dimmest) .. 15 (full), used live
//   display      segments g..a (bit6=g), polarity per SEG_ACTIVE_LOW
//   dp           decimal point, polarity per SEG_ACTIVE_LOW
//   select       one-hot digit enable, polarity per SEL_ACTIVE_LOW
//   frame_start  one-cycle pulse in the first cycle of digit 0's slot
//
// Timing: every output register is loaded from the *next* scan position
// (cnt_d/idx_d), so in any cycle the outputs describe the current cnt/idx.
// A started flag holds the scan at position 0 on the first clock after
// reset, which makes frame_start high in the first cycle after rst drops.

module sevenseg_mux_n #(
   parameter int DIGITS         = 4,
   parameter int CLK_DIV        = 50000,
   parameter int BLANK_CYCLES   = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit SEL_ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_mask,
   input  logic [3:0]            bright,
   output logic [6:0]            display,
   output logic                  dp,
   output logic [DIGITS-1:0]     select,
   output logic                  frame_start
);

   localparam int CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int STEP = (CLK_DIV - BLANK_CYCLES) / 16;

   localparam logic [CW-1:0]     CNT_MAX = CW'(CLK_DIV - 1);
   localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
   localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? '1 : '0;

   typedef enum logic [1:0] {
      ST_BLANK = 2'd0,
      ST_ON    = 2'd1,
      ST_OFF   = 2'd2
   } slot_state_e;

   // scan position
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                started_q;

   // per-frame shadow of the display data
   logic [4*DIGITS-1:0] value_sh_q;
   logic [DIGITS-1:0]   dp_sh_q;
   logic [DIGITS-1:0]   blank_sh_q;

   slot_state_e         state_q, state_d;

   // registered outputs
   logic [6:0]          display_q, display_d;
   logic                dp_q, dp_d;
   logic [DIGITS-1:0]   select_q, select_d;
   logic                frame_start_q, frame_start_d;

   // combinational helpers
   int                  phase;
   int                  on_end;
   logic                on_cond;
   logic                dark;
   logic [3:0]          nib;
   logic                dp_bit;
   logic [DIGITS-1:0]   onehot;
   logic [DIGITS-1:0]   supp;
   logic [6:0]          seg_raw;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      logic [6:0] s;
      s = 7'h00;
      case (n)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         4'hF: s = 7'b1110001;
      endcase
      return s;
   endfunction

   always_comb begin
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      state_d       = state_q;
      phase         = 0;
      on_end        = 0;
      on_cond       = 1'b0;
      dark          = 1'b0;
      nib           = 4'h0;
      dp_bit        = 1'b0;
      onehot        = '0;
      supp          = '0;
      seg_raw       = 7'h00;
      display_d     = SEG_OFF;
      dp_d          = DP_OFF;
      select_d      = SEL_OFF;
      frame_start_d = 1'b0;

      // Scan counter; held at 0/0 for the first clock after reset.
      if (!started_q) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      frame_start_d = (cnt_d == '0) && (idx_d == '0);

`ifdef SEVENSEG_LZ_BLANK_EN
      // Walk from the top digit down; the first non-zero nibble or set dp
      // stops suppression for itself and everything below. Digit 0 is
      // outside the loop so it always shows.
      begin : lz_scan
         logic lz_run;
         lz_run = 1'b1;
         for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run  = lz_run & (value_sh_q[4*i +: 4] == 4'h0) & ~dp_sh_q[i];
            supp[i] = lz_run;
         end
      end
`endif

      // Pick the shadow data of the digit being scanned next cycle.
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_d == IW'(i)) begin
            nib       = value_sh_q[4*i +: 4];
            dp_bit    = dp_sh_q[i];
            dark      = blank_sh_q[i] | supp[i];
            onehot[i] = 1'b1;
         end
      end

      phase   = int'(cnt_d);
      on_end  = BLANK_CYCLES + (int'(bright) + 1) * STEP;
      on_cond = !dark && (phase < on_end);

      // Slot FSM; a new slot (phase back inside the dead time) always
      // returns to BLANK. ON/OFF track the live brightness window.
      case (state_q)
         ST_BLANK: begin
            if (phase >= BLANK_CYCLES) state_d = on_cond ? ST_ON : ST_OFF;
         end
         ST_ON: begin
            if (phase < BLANK_CYCLES) state_d = ST_BLANK;
            else if (!on_cond)        state_d = ST_OFF;
         end
         ST_OFF: begin
            if (phase < BLANK_CYCLES) state_d = ST_BLANK;
            else if (on_cond)         state_d = ST_ON;
         end
         default: state_d = ST_BLANK;
      endcase

      if (state_d == ST_ON) begin
         seg_raw   = seg_decode(nib);
         display_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
         dp_d      = SEG_ACTIVE_LOW ? ~dp_bit : dp_bit;
         select_d  = SEL_ACTIVE_LOW ? ~onehot : onehot;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         started_q     <= 1'b0;
         value_sh_q    <= '0;
         dp_sh_q       <= '0;
         blank_sh_q    <= '0;
         state_q       <= ST_BLANK;
         display_q     <= SEG_OFF;
         dp_q          <= DP_OFF;
         select_q      <= SEL_OFF;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         started_q     <= 1'b1;
         // Capture at the end of the frame_start cycle; the lit window of
         // digit 0 begins only after the dead time, so it sees new data.
         if (frame_start_q) begin
            value_sh_q <= value;
            dp_sh_q    <= dp_in;
            blank_sh_q <= blank_mask;
         end
         state_q       <= state_d;
         display_q     <= display_d;
         dp_q          <= dp_d;
         select_q      <= select_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign display     = display_q;
   assign dp          = dp_q;
   assign select      = select_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_mux_n.sv
// Directed bench for sevenseg_mux_n with DIGITS=4, CLK_DIV=20,
// BLANK_CYCLES=4 (STEP=1), segments active-low, selects active-high.
// Time base: tcyc counts cycles from the frame_start cycle after reset;
// slot s, count c of frame f is cycle 80*f + 20*s + c. Inputs change and
// outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_sevenseg_mux_n;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  blank_mask;
   logic [3:0]  bright;
   logic [6:0]  display;
   logic        dp;
   logic [3:0]  select;
   logic        frame_start;

   int n_vec = 0;
   int n_err = 0;
   int tcyc  = 0;

   sevenseg_mux_n #(
      .DIGITS         (4),
      .CLK_DIV        (20),
      .BLANK_CYCLES   (4),
      .SEG_ACTIVE_LOW (1'b1),
      .SEL_ACTIVE_LOW (1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .value       (value),
      .dp_in       (dp_in),
      .blank_mask  (blank_mask),
      .bright      (bright),
      .display     (display),
      .dp          (dp),
      .select      (select),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, tcyc);
      end
   endtask

   // Checks all four outputs at the current cycle.
   task automatic chk_out(input string tag, input logic [3:0] e_sel,
                          input logic [6:0] e_disp, input logic e_dp,
                          input logic e_fs);
      chk({tag, ".select"},      {4'h0, select},      {4'h0, e_sel});
      chk({tag, ".display"},     {1'b0, display},     {1'b0, e_disp});
      chk({tag, ".dp"},          {7'h00, dp},         {7'h00, e_dp});
      chk({tag, ".frame_start"}, {7'h00, frame_start}, {7'h00, e_fs});
   endtask

   // Advance to an absolute cycle, checking one-hot select on the way.
   task automatic adv_to(input int target);
      while (tcyc < target) begin
         @(negedge clk);
         tcyc++;
         n_vec++;
         assert ($countones(select) <= 1) else begin
            n_err++;
            $error("FAIL onehot: observed select %b expected at most one bit (cycle %0d)", select, tcyc);
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      value      = 16'h12AF;
      dp_in      = 4'b0000;
      blank_mask = 4'b0000;
      bright     = 4'd15;

      // Reset held 5 cycles: everything dark, no frame pulse.
      repeat (5) @(negedge clk);
      chk_out("reset", 4'b0000, 7'h7F, 1'b1, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      tcyc = 0;

      // Scan and decode, value 12AF at full brightness.
      chk_out("s0c0",  4'b0000, 7'h7F, 1'b1, 1'b1);
      adv_to(3);   chk_out("s0c3",  4'b0000, 7'h7F, 1'b1, 1'b0);
      adv_to(4);   chk_out("s0c4",  4'b0001, 7'h0E, 1'b1, 1'b0);
      adv_to(19);  chk_out("s0c19", 4'b0001, 7'h0E, 1'b1, 1'b0);
      adv_to(20);  chk_out("s1c0",  4'b0000, 7'h7F, 1'b1, 1'b0);
      adv_to(24);  chk_out("s1c4",  4'b0010, 7'h08, 1'b1, 1'b0);
      adv_to(44);  chk_out("s2c4",  4'b0100, 7'h24, 1'b1, 1'b0);
      adv_to(64);  chk_out("s3c4",  4'b1000, 7'h79, 1'b1, 1'b0);
      adv_to(79);  chk_out("s3c19", 4'b1000, 7'h79, 1'b1, 1'b0);
      adv_to(80);  chk_out("f1c0",  4'b0000, 7'h7F, 1'b1, 1'b1);

      // Brightness 0: lit only at count 4.
      bright = 4'd0;
      adv_to(84);  chk_out("b0_s0c4",  4'b0001, 7'h0E, 1'b1, 1'b0);
      adv_to(85);  chk_out("b0_s0c5",  4'b0000, 7'h7F, 1'b1, 1'b0);
      adv_to(104); chk_out("b0_s1c4",  4'b0010, 7'h08, 1'b1, 1'b0);
      adv_to(105); chk_out("b0_s1c5",  4'b0000, 7'h7F, 1'b1, 1'b0);

      // Brightness 7: lit at counts 4..11.
      adv_to(160); chk_out("f2c0",     4'b0000, 7'h7F, 1'b1, 1'b1);
      bright = 4'd7;
      adv_to(164); chk_out("b7_s0c4",  4'b0001, 7'h0E, 1'b1, 1'b0);
      adv_to(171); chk_out("b7_s0c11", 4'b0001, 7'h0E, 1'b1, 1'b0);
      adv_to(172); chk_out("b7_s0c12", 4'b0000, 7'h7F, 1'b1, 1'b0);
      adv_to(231); chk_out("b7_s3c11", 4'b1000, 7'h79, 1'b1, 1'b0);
      adv_to(232); chk_out("b7_s3c12", 4'b0000, 7'h7F, 1'b1, 1'b0);

      // Frame latch: 1234 latched at cycle 240, 5678 arrives mid-frame.
      adv_to(240);
      value  = 16'h1234;
      bright = 4'd15;
      adv_to(244); chk_out("fl_s0", 4'b0001, 7'h19, 1'b1, 1'b0);
      adv_to(264); chk_out("fl_s1", 4'b0010, 7'h30, 1'b1, 1'b0);
      adv_to(270);
      value = 16'h5678;
      adv_to(274); chk_out("fl_s1_after", 4'b0010, 7'h30, 1'b1, 1'b0);
      adv_to(284); chk_out("fl_s2", 4'b0100, 7'h24, 1'b1, 1'b0);
      adv_to(304); chk_out("fl_s3", 4'b1000, 7'h79, 1'b1, 1'b0);
      adv_to(320); chk_out("f4c0",  4'b0000, 7'h7F, 1'b1, 1'b1);

      // New frame shows 5678; digit 2 blanked, dp on digit 1.
      blank_mask = 4'b0100;
      dp_in      = 4'b0010;
      adv_to(324); chk_out("nf_s0",     4'b0001, 7'h00, 1'b1, 1'b0);
      adv_to(344); chk_out("nf_s1",     4'b0010, 7'h78, 1'b0, 1'b0);
      adv_to(364); chk_out("blank_s2",  4'b0000, 7'h7F, 1'b1, 1'b0);
      adv_to(379); chk_out("blank_s2e", 4'b0000, 7'h7F, 1'b1, 1'b0);
      adv_to(384); chk_out("nf_s3",     4'b1000, 7'h12, 1'b1, 1'b0);

      // Zero handling, value 0050.
      adv_to(400);
      value      = 16'h0050;
      dp_in      = 4'b0000;
      blank_mask = 4'b0000;
      adv_to(404); chk_out("z50_s0", 4'b0001, 7'h40, 1'b1, 1'b0);
      adv_to(424); chk_out("z50_s1", 4'b0010, 7'h12, 1'b1, 1'b0);
`ifdef SEVENSEG_LZ_BLANK_EN
      adv_to(444); chk_out("z50_s2", 4'b0000, 7'h7F, 1'b1, 1'b0);
      adv_to(464); chk_out("z50_s3", 4'b0000, 7'h7F, 1'b1, 1'b0);
`else
      adv_to(444); chk_out("z50_s2", 4'b0100, 7'h40, 1'b1, 1'b0);
      adv_to(464); chk_out("z50_s3", 4'b1000, 7'h40, 1'b1, 1'b0);
`endif

      // Zero handling, value 0000 with dp on digit 2.
      adv_to(480);
      value = 16'h0000;
      dp_in = 4'b0100;
      adv_to(484); chk_out("z00_s0", 4'b0001, 7'h40, 1'b1, 1'b0);
      adv_to(504); chk_out("z00_s1", 4'b0010, 7'h40, 1'b1, 1'b0);
      adv_to(524); chk_out("z00_s2", 4'b0100, 7'h40, 1'b0, 1'b0);
`ifdef SEVENSEG_LZ_BLANK_EN
      adv_to(544); chk_out("z00_s3", 4'b0000, 7'h7F, 1'b1, 1'b0);
`else
      adv_to(544); chk_out("z00_s3", 4'b1000, 7'h40, 1'b1, 1'b0);
`endif

      // Mid-operation reset at slot 2, count 10 of frame 7.
      adv_to(610); chk_out("pre_rst", 4'b0100, 7'h40, 1'b0, 1'b0);
      rst = 1'b1;
      adv_to(611); chk_out("mid_rst", 4'b0000, 7'h7F, 1'b1, 1'b0);
      rst = 1'b0;
      adv_to(612); chk_out("rst_fs",  4'b0000, 7'h7F, 1'b1, 1'b1);
      adv_to(616); chk_out("rst_s0",  4'b0001, 7'h40, 1'b1, 1'b0);
      adv_to(636); chk_out("rst_s1",  4'b0010, 7'h40, 1'b1, 1'b0);
      adv_to(692); chk_out("rst_f1",  4'b0000, 7'h7F, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
